cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Shares the single ROB result write port between the three execution-side producers: ALU, LSB and Branch unit. Each producer pushes results into its own small FIFO. A round-robin arbiter pops at most one entry per cycle onto a registered common data bus (CDB) feeding the ROB write/forwarding logic. The block sits between the functional units and the ROB, and is flushed by the ROB's `clear`.

## Interface
Parameters:
- `TAG_W`, 4, ROB tag width
- `DATA_W`, 32, result data width
- `ADDR_W`, 32, branch target PC width
- `DEPTH`, 2, entries per producer FIFO (power of two, ≥2)

Ports:
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: synchronous, active-high reset
- `rdy` in 1: global enable; low freezes all state
- `clear` in 1: ROB misprediction flush
- `alu_valid` in 1; `alu_tag` in TAG_W; `alu_data` in DATA_W: ALU result push
- `alu_full` out 1: ALU FIFO holds DEPTH entries
- `lsb_valid` in 1; `lsb_tag` in TAG_W; `lsb_data` in DATA_W: LSB result push
- `lsb_full` out 1: LSB FIFO holds DEPTH entries
- `br_valid` in 1; `br_tag` in TAG_W; `br_data` in DATA_W; `br_jump_judge` in 1; `br_pc` in ADDR_W: Branch result push
- `br_full` out 1: Branch FIFO holds DEPTH entries
- `cdb_valid` out 1: CDB carries a result this cycle
- `cdb_src` out 2: winning source; 0 = ALU, 1 = LSB, 2 = Branch
- `cdb_tag` out TAG_W; `cdb_data` out DATA_W: result
- `cdb_jump_judge` out 1; `cdb_pc` out ADDR_W: Branch fields; 0 when `cdb_src` ≠ 2
- `overflow` out 1: sticky; a push arrived while that FIFO was full

## Operation
- Three independent FIFOs, each with head/tail pointers of width log2(DEPTH) that wrap modulo DEPTH, plus a count of width log2(DEPTH)+1.
  - ALU and LSB entries hold {tag, data}.
  - Branch entries hold {tag, data, jump_judge, pc}.
- `*_full` is a combinational decode of count == DEPTH.
- Push: when `x_valid`, `rdy`, !`clear`, !`rst` and the FIFO is not full, write at tail and advance tail.
- Push while full:
  - The entry is dropped and `overflow` is set.
  - A same-cycle pop does not make room. The producer must check `x_full` in the cycle before it asserts valid.
- Arbitration, each `rdy` cycle with !`clear`:
  - Candidates are the non-empty FIFOs, judged on registered count, so a same-cycle push is not visible.
  - Round-robin pointer `last` ∈ {0,1,2}. Priority order is last+1, last+2, last+3, all mod 3.
  - The winner pops its head into the output register, and `last` becomes the winner.
  - With no candidate: `cdb_valid` is 0, the other CDB fields hold, and `last` is unchanged.
- Simultaneous push and pop on one FIFO: count is unchanged and both pointers advance.
- `clear`, with `rdy` high:
  - All FIFO counts and pointers go to 0 and `cdb_valid` is 0.
  - `last` is set to 2, and same-cycle pushes are discarded.
  - `overflow` is unchanged.
- `rdy` low:
  - No push, pop, clear or pointer change.
  - Outputs hold their values, including `cdb_valid`. The consumer qualifies with `rdy`.
- `rst` has priority over `clear`, and `clear` over `rdy`-gated activity.

## Timing
- Reset values:
  - `cdb_valid`, `cdb_src`, `cdb_tag`, `cdb_data`, `cdb_jump_judge`, `cdb_pc` and `overflow` are 0.
  - All FIFOs are empty, so all `*_full` are 0.
  - `last` = 2, so the ALU has first priority.
- Latency: a push sampled at edge E can be granted at edge E+1 at the earliest, and `cdb_valid` is high in the cycle after E+1.
- Throughput: one result per cycle in total. Under sustained requests from all three sources, each source is granted once every 3 cycles.
- Fairness bound: a non-empty FIFO is granted within 3 `rdy` cycles.
- `cdb_valid` is a registered one-cycle pulse per popped entry. Back-to-back grants produce back-to-back pulses.
- An entry popped at the same edge as `clear` does not exist: `clear` wins and `cdb_valid` = 0.

## Test plan
- Reset, then a single ALU push of tag 3, data 0x11. Response: `cdb_valid` high for exactly 1 cycle with src 0, tag 3, data 0x11, starting two edges after the push. `cdb_pc` = 0.
- All three sources push in the same cycle (ALU tag 1, LSB tag 2, BR tag 4 with jump_judge 1, pc 0x100). Response: grants in order ALU, LSB, BR on consecutive cycles. The BR beat shows jump_judge 1, pc 0x100.
- LSB pushes 3 times back to back with DEPTH 2 while ALU is also pushing. Response: `lsb_full` asserts after 2 stored entries and the third push is dropped. `overflow` goes to 1 and stays 1 through a later `clear`, clearing only on `rst`.
- `clear` with 2 entries queued in every FIFO. Response: the next cycle has `cdb_valid` 0 and all fulls 0. A push the cycle after `clear` is granted starting from ALU priority.
- `rdy` is held low for 3 cycles while `cdb_valid` = 1 and the BR FIFO is non-empty. Response: outputs and counts are frozen and a push during the stall is ignored. Arbitration resumes at the next `rdy` cycle with the same winner it would have chosen.
- Sustained pushes from ALU and BR only, for 10 cycles. Response: grants alternate 0, 2, 0, 2…, there is no overflow, and each FIFO count stays ≤ 1 in steady state.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single ROB result write port between the ALU,
// LSB and Branch producers. Each producer pushes into its own FIFO. A
// round-robin arbiter pops at most one entry per cycle into a registered
// common data bus (CDB).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   clear               ROB misprediction flush
//   alu_valid/tag/data  ALU result push;    alu_full: ALU FIFO full
//   lsb_valid/tag/data  LSB result push;    lsb_full: LSB FIFO full
//   br_valid/tag/data/jump_judge/pc
//                       Branch result push; br_full: Branch FIFO full
//   cdb_valid           one-cycle pulse per popped entry
//   cdb_src             0 = ALU, 1 = LSB, 2 = Branch
//   cdb_tag, cdb_data   popped result
//   cdb_jump_judge, cdb_pc  Branch fields, zero for other sources
//   overflow            sticky: a push arrived while its FIFO was full
module cdb_arbiter #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_full,
    input  logic              lsb_valid,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_data,
    output logic              lsb_full,
    input  logic              br_valid,
    input  logic [TAG_W-1:0]  br_tag,
    input  logic [DATA_W-1:0] br_data,
    input  logic              br_jump_judge,
    input  logic [ADDR_W-1:0] br_pc,
    output logic              br_full,
    output logic              cdb_valid,
    output logic [1:0]        cdb_src,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_jump_judge,
    output logic [ADDR_W-1:0] cdb_pc,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NSRC  = 3;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSB = 2'd1,
        SRC_BR  = 2'd2
    } src_e;

    // FIFO state, indexed by source
    logic [CNT_W-1:0]  count_q    [NSRC];
    logic [CNT_W-1:0]  count_d    [NSRC];
    logic [PTR_W-1:0]  head_q     [NSRC];
    logic [PTR_W-1:0]  head_d     [NSRC];
    logic [PTR_W-1:0]  tail_q     [NSRC];
    logic [PTR_W-1:0]  tail_d     [NSRC];
    logic [TAG_W-1:0]  tag_mem_q  [NSRC][DEPTH];
    logic [TAG_W-1:0]  tag_mem_d  [NSRC][DEPTH];
    logic [DATA_W-1:0] data_mem_q [NSRC][DEPTH];
    logic [DATA_W-1:0] data_mem_d [NSRC][DEPTH];
    // Branch-only payload
    logic              jj_mem_q   [DEPTH];
    logic              jj_mem_d   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];

    src_e              last_q, last_d;
    logic              overflow_q, overflow_d;

    logic              cdb_valid_q, cdb_valid_d;
    logic [1:0]        cdb_src_q, cdb_src_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic              cdb_jj_q, cdb_jj_d;
    logic [ADDR_W-1:0] cdb_pc_q, cdb_pc_d;

    // Per-source views of the push interfaces
    logic              push_req [NSRC];
    logic [TAG_W-1:0]  push_tag [NSRC];
    logic [DATA_W-1:0] push_data[NSRC];
    logic              full     [NSRC];
    logic              req      [NSRC];
    logic              push_ok  [NSRC];
    logic              pop      [NSRC];

    logic              win_valid;
    src_e              win;

    always_comb begin
        push_req[0]  = alu_valid;
        push_tag[0]  = alu_tag;
        push_data[0] = alu_data;
        push_req[1]  = lsb_valid;
        push_tag[1]  = lsb_tag;
        push_data[1] = lsb_data;
        push_req[2]  = br_valid;
        push_tag[2]  = br_tag;
        push_data[2] = br_data;
        for (int unsigned i = 0; i < NSRC; i++) begin
            full[i] = (count_q[i] == FULL_CNT);
            req[i]  = (count_q[i] != '0);
        end
    end

    // Round-robin: scan last+1, last+2, last+3 (mod 3) on registered counts
    always_comb begin
        win_valid = 1'b0;
        win       = SRC_ALU;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            int unsigned cand;
            cand = (32'(last_q) + k) % NSRC;
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win       = src_e'(cand[1:0]);
            end
        end
    end

    always_comb begin
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        tag_mem_d   = tag_mem_q;
        data_mem_d  = data_mem_q;
        jj_mem_d    = jj_mem_q;
        pc_mem_d    = pc_mem_q;
        last_d      = last_q;
        overflow_d  = overflow_q;
        cdb_valid_d = cdb_valid_q;
        cdb_src_d   = cdb_src_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_jj_d    = cdb_jj_q;
        cdb_pc_d    = cdb_pc_q;
        for (int unsigned i = 0; i < NSRC; i++) begin
            push_ok[i] = 1'b0;
            pop[i]     = 1'b0;
        end

        if (rdy && clear) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                count_d[i] = '0;
                head_d[i]  = '0;
                tail_d[i]  = '0;
            end
            cdb_valid_d = 1'b0;
            last_d      = SRC_BR;
        end else if (rdy) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                // fullness is judged before any same-cycle pop
                push_ok[i] = push_req[i] && !full[i];
                pop[i]     = win_valid && (32'(win) == i);
                if (push_req[i] && full[i]) begin
                    overflow_d = 1'b1;
                end
                if (push_ok[i]) begin
                    tag_mem_d[i][tail_q[i]]  = push_tag[i];
                    data_mem_d[i][tail_q[i]] = push_data[i];
                    tail_d[i]                = tail_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    head_d[i] = head_q[i] + PTR_W'(1);
                end
                count_d[i] = count_q[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
            end
            if (push_ok[2]) begin
                jj_mem_d[tail_q[2]] = br_jump_judge;
                pc_mem_d[tail_q[2]] = br_pc;
            end

            cdb_valid_d = win_valid;
            if (win_valid) begin
                cdb_src_d  = win;
                cdb_tag_d  = tag_mem_q[win][head_q[win]];
                cdb_data_d = data_mem_q[win][head_q[win]];
                cdb_jj_d   = 1'b0;
                cdb_pc_d   = '0;
                if (win == SRC_BR) begin
                    cdb_jj_d = jj_mem_q[head_q[2]];
                    cdb_pc_d = pc_mem_q[head_q[2]];
                end
                last_d = win;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '{default: '0};
            head_q      <= '{default: '0};
            tail_q      <= '{default: '0};
            tag_mem_q   <= '{default: '{default: '0}};
            data_mem_q  <= '{default: '{default: '0}};
            jj_mem_q    <= '{default: '0};
            pc_mem_q    <= '{default: '0};
            last_q      <= SRC_BR;
            overflow_q  <= 1'b0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_jj_q    <= 1'b0;
            cdb_pc_q    <= '0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            tag_mem_q   <= tag_mem_d;
            data_mem_q  <= data_mem_d;
            jj_mem_q    <= jj_mem_d;
            pc_mem_q    <= pc_mem_d;
            last_q      <= last_d;
            overflow_q  <= overflow_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_jj_q    <= cdb_jj_d;
            cdb_pc_q    <= cdb_pc_d;
        end
    end

    assign alu_full       = full[0];
    assign lsb_full       = full[1];
    assign br_full        = full[2];
    assign cdb_valid      = cdb_valid_q;
    assign cdb_src        = cdb_src_q;
    assign cdb_tag        = cdb_tag_q;
    assign cdb_data       = cdb_data_q;
    assign cdb_jump_judge = cdb_jj_q;
    assign cdb_pc         = cdb_pc_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter (default parameters,
// DEPTH = 2). Inputs change 1 time unit after each rising edge; outputs are
// checked at the same point, i.e. they reflect the edge just taken.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_tag = '0;
    logic [31:0] alu_data = '0;
    logic        alu_full;
    logic        lsb_valid = 1'b0;
    logic [3:0]  lsb_tag = '0;
    logic [31:0] lsb_data = '0;
    logic        lsb_full;
    logic        br_valid = 1'b0;
    logic [3:0]  br_tag = '0;
    logic [31:0] br_data = '0;
    logic        br_jump_judge = 1'b0;
    logic [31:0] br_pc = '0;
    logic        br_full;
    logic        cdb_valid;
    logic [1:0]  cdb_src;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_jump_judge;
    logic [31:0] cdb_pc;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter #(.TAG_W(4), .DATA_W(32), .ADDR_W(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data), .alu_full(alu_full),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_data(lsb_data), .lsb_full(lsb_full),
        .br_valid(br_valid), .br_tag(br_tag), .br_data(br_data),
        .br_jump_judge(br_jump_judge), .br_pc(br_pc), .br_full(br_full),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_jump_judge(cdb_jump_judge), .cdb_pc(cdb_pc), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Expect a CDB beat from the last edge
    task automatic beat(input string name, input logic [1:0] src, input logic [3:0] tag,
                        input logic [31:0] data, input logic jj, input logic [31:0] pc);
        chk({name, " valid"}, 64'(cdb_valid), 64'(1'b1));
        chk({name, " src"},   64'(cdb_src), 64'(src));
        chk({name, " tag"},   64'(cdb_tag), 64'(tag));
        chk({name, " data"},  64'(cdb_data), 64'(data));
        chk({name, " jj"},    64'(cdb_jump_judge), 64'(jj));
        chk({name, " pc"},    64'(cdb_pc), 64'(pc));
    endtask

    task automatic fulls(input string name, input logic a, input logic l, input logic b);
        chk({name, " alu_full"}, 64'(alu_full), 64'(a));
        chk({name, " lsb_full"}, 64'(lsb_full), 64'(l));
        chk({name, " br_full"},  64'(br_full), 64'(b));
    endtask

    initial begin
        // ---------------- reset ----------------
        tick(); tick();
        rst = 1'b0;
        chk("rst cdb_valid", 64'(cdb_valid), 64'(0));
        chk("rst cdb_src",   64'(cdb_src), 64'(0));
        chk("rst cdb_tag",   64'(cdb_tag), 64'(0));
        chk("rst cdb_data",  64'(cdb_data), 64'(0));
        chk("rst cdb_jj",    64'(cdb_jump_judge), 64'(0));
        chk("rst cdb_pc",    64'(cdb_pc), 64'(0));
        chk("rst overflow",  64'(overflow), 64'(0));
        fulls("rst", 0, 0, 0);

        // ---------------- single ALU push ----------------
        alu_valid = 1; alu_tag = 4'd3; alu_data = 32'h11;
        tick();
        alu_valid = 0;
        chk("single E valid", 64'(cdb_valid), 64'(0));
        tick();
        beat("single E+1", 2'd0, 4'd3, 32'h11, 1'b0, 32'h0);
        tick();
        chk("single pulse end", 64'(cdb_valid), 64'(0));

        // clear restores ALU-first priority (last was ALU)
        clear = 1;
        tick();
        clear = 0;

        // ---------------- all three push together ----------------
        alu_valid = 1; alu_tag = 4'd1; alu_data = 32'hA1;
        lsb_valid = 1; lsb_tag = 4'd2; lsb_data = 32'hB2;
        br_valid = 1; br_tag = 4'd4; br_data = 32'hC4; br_jump_judge = 1; br_pc = 32'h100;
        tick();
        alu_valid = 0; lsb_valid = 0; br_valid = 0;
        chk("all3 push-edge valid", 64'(cdb_valid), 64'(0));
        tick(); beat("all3 g1 ALU", 2'd0, 4'd1, 32'hA1, 1'b0, 32'h0);
        tick(); beat("all3 g2 LSB", 2'd1, 4'd2, 32'hB2, 1'b0, 32'h0);
        tick(); beat("all3 g3 BR",  2'd2, 4'd4, 32'hC4, 1'b1, 32'h100);
        tick(); chk("all3 idle", 64'(cdb_valid), 64'(0));

        // ---------------- LSB overflow (last = BR) ----------------
        alu_valid = 1; alu_tag = 4'd5; alu_data = 32'h55;
        lsb_valid = 1; lsb_tag = 4'd8; lsb_data = 32'h88;
        tick();                                   // counts A1 L1
        alu_tag = 4'd6; alu_data = 32'h66;
        lsb_tag = 4'd9; lsb_data = 32'h99;
        tick();                                   // ALU popped; A1 L2
        beat("ovf g ALU5", 2'd0, 4'd5, 32'h55, 1'b0, 32'h0);
        fulls("ovf two stored", 0, 1, 0);
        chk("ovf not yet", 64'(overflow), 64'(0));
        alu_tag = 4'd7; alu_data = 32'h77;
        lsb_tag = 4'd10; lsb_data = 32'hAA;
        tick();                                   // LSB push dropped; LSB popped; A2 L1
        alu_valid = 0; lsb_valid = 0;
        chk("ovf set", 64'(overflow), 64'(1));
        beat("ovf g LSB8", 2'd1, 4'd8, 32'h88, 1'b0, 32'h0);
        fulls("ovf after drop", 1, 0, 0);
        tick(); beat("ovf g ALU6", 2'd0, 4'd6, 32'h66, 1'b0, 32'h0);
        tick(); beat("ovf g LSB9", 2'd1, 4'd9, 32'h99, 1'b0, 32'h0);
        tick(); beat("ovf g ALU7", 2'd0, 4'd7, 32'h77, 1'b0, 32'h0);
        tick(); chk("ovf drained", 64'(cdb_valid), 64'(0));
        chk("ovf sticky", 64'(overflow), 64'(1));

        // ---------------- clear with queued entries (last = ALU) ----------------
        alu_valid = 1; alu_tag = 4'd1; alu_data = 32'h1;
        lsb_valid = 1; lsb_tag = 4'd2; lsb_data = 32'h2;
        br_valid = 1; br_tag = 4'd3; br_data = 32'h3; br_jump_judge = 0; br_pc = 32'h300;
        tick();                                   // A1 L1 B1
        tick();                                   // LSB popped: A2 L1 B2
        beat("clr pre g LSB", 2'd1, 4'd2, 32'h2, 1'b0, 32'h0);
        fulls("clr pre", 1, 0, 1);
        lsb_valid = 0; br_valid = 0;
        alu_tag = 4'd15; alu_data = 32'hFF;       // discarded by clear
        clear = 1;
        tick();
        clear = 0;
        chk("clr valid", 64'(cdb_valid), 64'(0));
        fulls("clr", 0, 0, 0);
        chk("clr overflow kept", 64'(overflow), 64'(1));
        alu_valid = 1; alu_tag = 4'hA; alu_data = 32'hA0;
        lsb_valid = 1; lsb_tag = 4'hB; lsb_data = 32'hB0;
        br_valid = 1; br_tag = 4'hC; br_data = 32'hC0; br_jump_judge = 0; br_pc = 32'h200;
        tick();
        alu_valid = 0; lsb_valid = 0; br_valid = 0;
        chk("post-clr push-edge valid", 64'(cdb_valid), 64'(0));
        tick(); beat("post-clr g ALU", 2'd0, 4'hA, 32'hA0, 1'b0, 32'h0);
        tick(); beat("post-clr g LSB", 2'd1, 4'hB, 32'hB0, 1'b0, 32'h0);

        // ---------------- rdy stall (BR still queued, last = LSB) ----------------
        rdy = 0;
        alu_valid = 1; alu_tag = 4'hD; alu_data = 32'hD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            beat("stall hold", 2'd1, 4'hB, 32'hB0, 1'b0, 32'h0);
        end
        alu_valid = 0;
        rdy = 1;
        tick(); beat("resume g BR", 2'd2, 4'hC, 32'hC0, 1'b0, 32'h200);
        tick(); chk("stall push ignored", 64'(cdb_valid), 64'(0));

        // ---------------- reset clears overflow; alternating ALU/BR ----------------
        rst = 1;
        tick();
        rst = 0;
        chk("rst2 overflow", 64'(overflow), 64'(0));
        chk("rst2 valid", 64'(cdb_valid), 64'(0));
        // step k pushes ALU (odd k) or BR (even k) with tag k; grant at step k
        // pops the entry pushed at step k-1
        for (int k = 1; k <= 10; k++) begin
            alu_valid = (k % 2 == 1);
            br_valid  = (k % 2 == 0);
            alu_tag = 4'(k); alu_data = 32'(k);
            br_tag  = 4'(k); br_data  = 32'(k); br_jump_judge = 0; br_pc = 32'(k * 16);
            tick();
            if (k == 1) begin
                chk("alt k1 valid", 64'(cdb_valid), 64'(0));
            end else if (k % 2 == 0) begin
                beat("alt ALU", 2'd0, 4'(k - 1), 32'(k - 1), 1'b0, 32'h0);
            end else begin
                beat("alt BR", 2'd2, 4'(k - 1), 32'(k - 1), 1'b0, 32'((k - 1) * 16));
            end
            fulls("alt", 0, 0, 0);
        end
        alu_valid = 0; br_valid = 0;
        tick(); beat("alt last BR", 2'd2, 4'd10, 32'd10, 1'b0, 32'd160);
        tick(); chk("alt idle", 64'(cdb_valid), 64'(0));
        chk("alt no overflow", 64'(overflow), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
